// File: rtl/fcpu_rd_arbiter_if.sv
// AXI4 read-path bundle between the requester channels, the arbiter and the memory-side read port.
// Each requester's address and length sit at [i*W +: W]; R data is shared and qualified per channel by ch_rvalid.
interface fcpu_rd_arbiter_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
);
  logic [N_CH-1:0]        ch_arvalid;
  logic [N_CH-1:0]        ch_arready;
  logic [N_CH*ADDR_W-1:0] ch_araddr;
  logic [N_CH*8-1:0]      ch_arlen;
  logic [N_CH-1:0]        ch_rvalid;
  logic [N_CH-1:0]        ch_rready;
  logic [DATA_W-1:0]      ch_rdata;
  logic [1:0]             ch_rresp;
  logic                   ch_rlast;

  logic [ID_W-1:0]        m_arid;
  logic [ADDR_W-1:0]      m_araddr;
  logic [7:0]             m_arlen;
  logic [2:0]             m_arsize;
  logic [1:0]             m_arburst;
  logic                   m_arvalid;
  logic                   m_arready;
  logic [ID_W-1:0]        m_rid;
  logic [DATA_W-1:0]      m_rdata;
  logic [1:0]             m_rresp;
  logic                   m_rlast;
  logic                   m_rvalid;
  logic                   m_rready;

  // Arbiter view: it serves the requester channels and masters the memory port
  modport master (
    input  ch_arvalid, ch_araddr, ch_arlen, ch_rready,
    input  m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    output ch_arready, ch_rvalid, ch_rdata, ch_rresp, ch_rlast,
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
  );

  // Environment view: requesters plus memory
  modport slave (
    output ch_arvalid, ch_araddr, ch_arlen, ch_rready,
    output m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    input  ch_arready, ch_rvalid, ch_rdata, ch_rresp, ch_rlast,
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
  );
endinterface

// File: rtl/fcpu_rd_arbiter.sv
// N-channel AXI4 read arbiter: round-robin AR merge through a one-entry slice, ID-tagged bursts,
// per-channel outstanding limits and RID-routed R beats with sticky illegal-RID detection.
module fcpu_rd_arbiter #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic               clk,
  input  logic               nrst,
  fcpu_rd_arbiter_if.master  bus,
  output logic               err_rid
);
  localparam int unsigned PTR_W = $clog2(N_CH);
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
  localparam logic [ID_W:0]    ID_LIM  = (ID_W+1)'(N_CH);

  logic [CNT_W-1:0] out_cnt [N_CH];
  logic [PTR_W-1:0] rr_ptr;
  logic [N_CH-1:0]  eligible;
  logic [N_CH-1:0]  cnt_inc;
  logic [N_CH-1:0]  cnt_dec;
  logic             slot_free;
  logic             found;
  logic             accept;
  logic [PTR_W-1:0] grant;
  int unsigned      scan_idx;
  logic [PTR_W-1:0] rid_idx;
  logic             rid_legal;
  logic             r_done;

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      eligible[i] = bus.ch_arvalid[i] && (out_cnt[i] < CNT_MAX);
    end
  end

  // Round-robin scan: first eligible channel at or after rr_ptr, wrapping
  always_comb begin
    found    = 1'b0;
    grant    = '0;
    scan_idx = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      scan_idx = (32'(rr_ptr) + k) % N_CH;
      if (!found && eligible[PTR_W'(scan_idx)]) begin
        found = 1'b1;
        grant = PTR_W'(scan_idx);
      end
    end
  end

  assign slot_free      = !bus.m_arvalid || bus.m_arready;
  assign accept         = found && slot_free;
  assign bus.ch_arready = accept ? (N_CH'(1) << grant) : '0;
  assign cnt_inc        = bus.ch_arready;

  // Beats are legal only for an in-range channel that actually has a burst in flight
  assign rid_idx   = bus.m_rid[PTR_W-1:0];
  assign rid_legal = ({1'b0, bus.m_rid} < ID_LIM) && (out_cnt[rid_idx] != '0);
  assign r_done    = rid_legal && bus.m_rvalid && bus.ch_rready[rid_idx] && bus.m_rlast;
  assign cnt_dec   = r_done ? (N_CH'(1) << rid_idx) : '0;

  assign bus.ch_rvalid = (rid_legal && bus.m_rvalid) ? (N_CH'(1) << rid_idx) : '0;
  assign bus.m_rready  = rid_legal ? bus.ch_rready[rid_idx] : 1'b1;
  assign bus.ch_rdata  = bus.m_rdata;
  assign bus.ch_rresp  = bus.m_rresp;
  assign bus.ch_rlast  = bus.m_rlast;

  assign bus.m_arsize  = 3'($clog2(DATA_W / 8));
  assign bus.m_arburst = 2'b01;

  // AR slice and round-robin pointer
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bus.m_arvalid <= 1'b0;
      bus.m_arid    <= '0;
      bus.m_araddr  <= '0;
      bus.m_arlen   <= '0;
      rr_ptr        <= '0;
    end else if (slot_free) begin
      bus.m_arvalid <= accept;
      if (accept) begin
        bus.m_arid   <= ID_W'(grant);
        bus.m_araddr <= bus.ch_araddr[32'(grant)*ADDR_W +: ADDR_W];
        bus.m_arlen  <= bus.ch_arlen[32'(grant)*8 +: 8];
        rr_ptr       <= (grant == PTR_W'(N_CH - 1)) ? '0 : grant + PTR_W'(1);
      end
    end
  end

  // Outstanding-burst counters; a same-cycle grant and rlast cancel
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < N_CH; i++) out_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (cnt_inc[i] && !cnt_dec[i])      out_cnt[i] <= out_cnt[i] + CNT_W'(1);
        else if (cnt_dec[i] && !cnt_inc[i]) out_cnt[i] <= out_cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                           err_rid <= 1'b0;
    else if (bus.m_rvalid && !rid_legal) err_rid <= 1'b1;
  end
endmodule
